// File: rtl/ex_mem_stage.sv
// EX/MEM valid/ready stage with a one-entry skid buffer: 1-cycle latency, full throughput.
// in_ready_o depends only on local state and flush_i; when MEM stalls, one extra entry parks in skid.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              zero_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              zero_o,
  output logic [DATA_W-1:0] alu_data_o,
  output logic [DATA_W-1:0] write_data_o,
  output logic [REG_AW-1:0] rd_addr_o
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              zero;
    logic [DATA_W-1:0] alu_data;
    logic [DATA_W-1:0] write_data;
    logic [REG_AW-1:0] rd_addr;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  entry_t r_main;
  entry_t r_skid;
  entry_t w_in;
  logic   w_ix;
  logic   w_ox;
  logic   w_main_ld_in;
  logic   w_main_ld_skid;
  logic   w_skid_ld;

  assign w_in        = {ctrl_i, zero_i, alu_data_i, write_data_i, rd_addr_i};
  assign in_ready_o  = (r_state != ST_SKID) & ~flush_i;
  assign out_valid_o = (r_state != ST_EMPTY);
  assign w_ix        = in_valid_i & in_ready_o;
  assign w_ox        = out_valid_o & out_ready_i;

  always_comb begin
    w_state_nxt    = r_state;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_ix) begin
            w_state_nxt  = ST_FULL;
            w_main_ld_in = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_ix && w_ox) begin
            w_main_ld_in = 1'b1;
          end else if (w_ix) begin
            w_state_nxt = ST_SKID;
            w_skid_ld   = 1'b1;
          end else if (w_ox) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (w_ox) begin
            w_state_nxt    = ST_FULL;
            w_main_ld_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Data registers only move on loads, so outputs keep their last value while invalid.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_main_ld_in) begin
        r_main <= w_in;
      end else if (w_main_ld_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_ld) begin
        r_skid <= w_in;
      end
    end
  end

  assign ctrl_o       = out_valid_o ? r_main.ctrl : '0;
  assign zero_o       = r_main.zero;
  assign alu_data_o   = r_main.alu_data;
  assign write_data_o = r_main.write_data;
  assign rd_addr_o    = r_main.rd_addr;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: default-width instance plus a 64-bit/6-bit instance.
module tb_ex_mem_stage;

  localparam int AW = 75;
  localparam int BW = 140;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_zero, a_zero_o;
  logic [4:0]  a_ctrl, a_ctrl_o, a_rd, a_rd_o;
  logic [31:0] a_alu, a_alu_o, a_wd, a_wd_o;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_zero, b_zero_o;
  logic [4:0]  b_ctrl, b_ctrl_o;
  logic [5:0]  b_rd, b_rd_o;
  logic [63:0] b_alu, b_alu_o, b_wd, b_wd_o;

  int tests = 0;
  int fails = 0;

  logic [AW-1:0] qa[$];
  logic [BW-1:0] qb[$];

  ex_mem_stage u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .ctrl_i(a_ctrl), .zero_i(a_zero), .alu_data_i(a_alu), .write_data_i(a_wd), .rd_addr_i(a_rd),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .ctrl_o(a_ctrl_o), .zero_o(a_zero_o), .alu_data_o(a_alu_o), .write_data_o(a_wd_o), .rd_addr_o(a_rd_o)
  );

  ex_mem_stage #(.DATA_W(64), .REG_AW(6), .CTRL_W(5)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .ctrl_i(b_ctrl), .zero_i(b_zero), .alu_data_i(b_alu), .write_data_i(b_wd), .rd_addr_i(b_rd),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .ctrl_o(b_ctrl_o), .zero_o(b_zero_o), .alu_data_o(b_alu_o), .write_data_o(b_wd_o), .rd_addr_o(b_rd_o)
  );

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entry layout {ctrl, zero, alu_data, write_data, rd_addr}; ctrl bit 0 (RegWrite) always set.
  function automatic logic [AW-1:0] mk_a(input logic [31:0] v);
    return {v[3:0], 1'b1, v[1], v, ~v, v[4:0]};
  endfunction

  function automatic logic [BW-1:0] mk_b(input logic [63:0] v, input logic [5:0] rd);
    return {5'b01001, v[0], v, {v[31:0], v[63:32]}, rd};
  endfunction

  // Monitors: every output transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) chk("a_unexpected_out", 140'(a_alu_o), 140'(0));
      else chk("a_out", 140'({a_ctrl_o, a_zero_o, a_alu_o, a_wd_o, a_rd_o}), 140'(qa.pop_front()));
    end
    if (rst_n && !a_out_valid) chk("a_bubble_ctrl", 140'(a_ctrl_o), 140'(0));
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_out", 140'(b_alu_o), 140'(0));
      else chk("b_out", {b_ctrl_o, b_zero_o, b_alu_o, b_wd_o, b_rd_o}, qb.pop_front());
    end
  end

  task automatic offer_a(input logic [31:0] v, input bit acc);
    logic [AW-1:0] e;
    e = mk_a(v);
    {a_ctrl, a_zero, a_alu, a_wd, a_rd} = e;
    a_in_valid = 1'b1;
    @(negedge clk);
    chk("a_in_ready", 140'(a_in_ready), 140'(acc));
    if (acc) qa.push_back(e);
    @(posedge clk);
    #1 a_in_valid = 1'b0;
  endtask

  task automatic offer_b(input logic [63:0] v, input logic [5:0] rd, input bit acc);
    logic [BW-1:0] e;
    e = mk_b(v, rd);
    {b_ctrl, b_zero, b_alu, b_wd, b_rd} = e;
    b_in_valid = 1'b1;
    @(negedge clk);
    chk("b_in_ready", 140'(b_in_ready), 140'(acc));
    if (acc) qb.push_back(e);
    @(posedge clk);
    #1 b_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while (qa.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("a_drain_left", 140'(qa.size()), 140'(0));
  endtask

  task automatic drain_b();
    int n = 0;
    while (qb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("b_drain_left", 140'(qb.size()), 140'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    {a_ctrl, a_zero, a_alu, a_wd, a_rd} = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    {b_ctrl, b_zero, b_alu, b_wd, b_rd} = '0;

    #3;
    chk("rst_a_out_valid", 140'(a_out_valid), 140'(0));
    chk("rst_a_ctrl", 140'(a_ctrl_o), 140'(0));
    chk("rst_a_data", 140'({a_zero_o, a_alu_o, a_wd_o, a_rd_o}), 140'(0));
    chk("rst_a_in_ready", 140'(a_in_ready), 140'(1));
    chk("rst_b_data", 140'({b_out_valid, b_ctrl_o, b_zero_o, b_alu_o, b_wd_o, b_rd_o}), 140'(0));
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // Streaming at full rate
    for (int v = 1; v <= 4; v++) offer_a(32'(v), 1'b1);
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      chk("bubble_valid", 140'(a_out_valid), 140'(0));
      chk("bubble_ctrl", 140'(a_ctrl_o), 140'(0));
    end
    @(posedge clk); #1;

    // Stall fill into skid, then release
    a_out_ready = 1'b0;
    offer_a(32'hA, 1'b1);
    offer_a(32'hB, 1'b1);
    @(negedge clk);
    chk("skid_in_ready", 140'(a_in_ready), 140'(0));
    chk("skid_head_alu", 140'(a_alu_o), 140'(32'hA));
    @(posedge clk); #1 a_out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready0", 140'(a_in_ready), 140'(0));
    @(negedge clk);
    chk("release_in_ready1", 140'(a_in_ready), 140'(1));
    @(posedge clk); #1;
    drain_a();

    // Flush while in skid, with an offered entry 0xC
    a_out_ready = 1'b0;
    offer_a(32'h11, 1'b1);
    offer_a(32'h12, 1'b1);
    a_flush = 1'b1;
    offer_a(32'hC, 1'b0);
    a_flush = 1'b0;
    qa.delete();
    @(negedge clk);
    chk("flush_valid", 140'(a_out_valid), 140'(0));
    chk("flush_ctrl", 140'(a_ctrl_o), 140'(0));
    chk("flush_hold_alu", 140'(a_alu_o), 140'(32'h11));
    @(posedge clk); #1 a_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset while in skid
    a_out_ready = 1'b0;
    offer_a(32'h21, 1'b1);
    offer_a(32'h22, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 140'(a_out_valid), 140'(0));
    chk("arst_ctrl", 140'(a_ctrl_o), 140'(0));
    chk("arst_data", 140'({a_zero_o, a_alu_o, a_wd_o, a_rd_o}), 140'(0));
    qa.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1 a_out_ready = 1'b1;
    offer_a(32'hD, 1'b1);
    #3;
    chk("post_rst_valid", 140'(a_out_valid), 140'(1));
    chk("post_rst_alu", 140'(a_alu_o), 140'(32'hD));
    @(posedge clk); #1;
    drain_a();

    // Wide instance: bit-exact pass-through and stall ordering
    offer_b(64'hFFFF_0000_1234_5678, 6'd63, 1'b1);
    #3;
    chk("b_alu_exact", 140'(b_alu_o), 140'(64'hFFFF_0000_1234_5678));
    chk("b_rd_exact", 140'(b_rd_o), 140'(6'd63));
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    offer_b(64'h8000_0000_0000_000A, 6'd10, 1'b1);
    offer_b(64'h0123_4567_89AB_CDEF, 6'd33, 1'b1);
    @(negedge clk);
    chk("b_skid_in_ready", 140'(b_in_ready), 140'(0));
    @(posedge clk); #1 b_out_ready = 1'b1;
    drain_b();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
